// File: rtl/s_mem_arbiter.sv
// Request/grant arbiter with per-requester lock that shares the single-port S-memory
// between the RC4 init (0), shuffle (1) and decrypt (2) FSMs. Read returns are tagged
// back to their issuer. Define SMEM_ARB_FIXED_PRIO_EN for fixed priority 2 > 1 > 0.
module s_mem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [2:0]      req,
  input  logic [2:0]      lock,
  input  logic [2:0]      wren,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic [AW-1:0]   mem_address,
  output logic [DW-1:0]   mem_data,
  output logic            mem_wren,
  input  logic [DW-1:0]   mem_q
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              owner_reg, owner_next;
  logic [1:0]              ptr_reg, ptr_next;
  logic [2:0]              gnt_reg, gnt_next;
  logic [1:0]              winner;
  logic                    issue;
  logic                    rd_issue;
  logic [AW-1:0]           addr_arr  [3];
  logic [DW-1:0]           wdata_arr [3];
  logic [RD_LATENCY-1:0]   tag_vld_reg, tag_vld_next;
  logic [2*RD_LATENCY-1:0] tag_id_reg, tag_id_next;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr[gi*AW +: AW];
      assign wdata_arr[gi] = wdata[gi*DW +: DW];
    end
  endgenerate

`ifdef SMEM_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = 2'd0;
    if (req[2])      winner = 2'd2;
    else if (req[1]) winner = 2'd1;
  end
`else
  logic [1:0] cand;
  logic       found;

  // Search starts at the requester after the last owner, wrapping modulo 3.
  always_comb begin
    winner = 2'd0;
    cand   = 2'd0;
    found  = 1'b0;
    for (int off = 1; off <= 3; off++) begin
      cand = 2'((int'(ptr_reg) + off) % 3);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end
`endif

  // State register; pointer resets to 2 so requester 0 is searched first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      owner_reg <= 2'd0;
      ptr_reg   <= 2'd2;
      gnt_reg   <= 3'b000;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = OWN;
          owner_next = winner;
          gnt_next   = 3'(3'b001 << winner);
        end
      end
      OWN: begin
        if (!req[owner_reg] && !lock[owner_reg]) begin
          state_next = IDLE;
          gnt_next   = 3'b000;
          ptr_next   = owner_reg;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 3'b000;
      end
    endcase
  end

  // Memory port follows the owner; a locked owner without req drives no access.
  always_comb begin
    issue       = gnt_reg[owner_reg] & req[owner_reg];
    rd_issue    = issue & ~wren[owner_reg];
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (|gnt_reg) begin
      mem_address = addr_arr[owner_reg];
      mem_data    = wdata_arr[owner_reg];
      mem_wren    = issue & wren[owner_reg];
    end
  end

  assign gnt = gnt_reg;

  always_comb begin
    tag_vld_next = RD_LATENCY'({tag_vld_reg, rd_issue});
    tag_id_next  = (2*RD_LATENCY)'({tag_id_reg, owner_reg});
  end

  // Tags keep flowing after release so in-flight reads reach their original issuer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld_reg <= '0;
      tag_id_reg  <= '0;
    end else begin
      tag_vld_reg <= tag_vld_next;
      tag_id_reg  <= tag_id_next;
    end
  end

  always_comb begin
    rvalid = 3'b000;
    if (tag_vld_reg[RD_LATENCY-1])
      rvalid[tag_id_reg[(RD_LATENCY-1)*2 +: 2]] = 1'b1;
  end

  assign rdata = mem_q;

endmodule

// File: doc/s_mem_arbiter.md
Name: s_mem_arbiter

Overview:
- Shares the single-port 256x8 S-memory between three RC4 phase FSMs: 0 = init, 1 = shuffle (KSA swap), 2 = decrypt (PRGA).
- Grant protocol is request/grant with optional lock, so the read-i / read-j / write-i / write-j swap is atomic.
- Each read data return is tagged back to the requester that issued it.
- Sits between the phase FSMs and s_memory. It replaces static select-based routing.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- RD_LATENCY, 1, cycles from read issue to valid mem_q (1..3).

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset_n  in  1  asynchronous active-low reset
- req  in  3  per-requester access request, bit i = requester i
- lock  in  3  per-requester hold-grant-while-idle
- wren  in  3  per-requester write enable
- addr  in  3*AW  flattened addresses, requester i at [i*AW +: AW]
- wdata  in  3*DW  flattened write data
- gnt  out  3  one-hot or zero grant
- rvalid  out  3  per-requester read-data-valid pulse
- rdata  out  DW  shared read data, equal to mem_q
- mem_address  out  AW  to s_memory
- mem_data  out  DW  to s_memory
- mem_wren  out  1  to s_memory
- mem_q  in  DW  from s_memory

Behaviour:
- Reset (asynchronous, while reset_n = 0):
  - gnt = 0, rvalid = 0, mem_wren = 0, mem_address = 0, mem_data = 0.
  - FSM goes to IDLE; round-robin pointer set to favour requester 0.
  - Read-tag pipeline cleared; in-flight reads are discarded and never return.
- FSM states: IDLE (no owner) and OWN (one owner, gnt one-hot, registered).
- IDLE:
  - If any req bit is high, pick the winner round-robin, starting from the requester after the last owner.
  - gnt[winner] asserts on the next edge; state goes to OWN.
  - With no req, stay in IDLE.
- OWN, owner k:
  - Stay while req[k] = 1 or lock[k] = 1.
  - When req[k] = 0 and lock[k] = 0, clear gnt on the next edge, go to IDLE and set pointer = k.
  - Handoff therefore shows at least one cycle with gnt = 0.
  - Other requests are ignored until release. No preemption.
- Access issue: a cycle where gnt[k] = 1 and req[k] = 1.
  - mem_address, mem_data and mem_wren follow requester k's addr, wdata and wren slices combinationally.
  - mem_wren = wren[k] & req[k] & gnt[k]; otherwise 0.
- Read issue: gnt[k] & req[k] & ~wren[k].
  - Requester id k is pushed into a RD_LATENCY-deep tag shift register.
  - rvalid[k] pulses exactly RD_LATENCY cycles later, with rdata = mem_q in that cycle.
  - One issue per cycle, fully pipelined, back-to-back reads allowed.
- Release with reads in flight: their rvalid is still delivered to the original requester, even while the next owner is granted.
- Lock with req = 0: grant is held but mem_wren = 0 and no read is issued.
- Address/data width: no arithmetic; values pass through unmodified. Address wrap is the requester's responsibility.
- Simultaneous requests in IDLE: exactly one winner per arbitration. Bits other than the winner are never asserted on gnt.

Optional Feature:
- Macro: SMEM_ARB_FIXED_PRIO_EN.
- Defined: IDLE uses fixed priority 2 > 1 > 0 (decrypt highest); the pointer is unused.
- Undefined: round-robin as described above.
- Everything else is identical in both builds.

Test Plan:
- Reset then req = 3'b001, wren[0] = 1, addr0 = 8'h05, wdata0 = 8'h05:
  - gnt = 3'b001 one cycle after req.
  - mem_wren = 1 with mem_address = 8'h05, mem_data = 8'h05.
- Owner 1 reads addr 8'h10 and memory returns 8'hA7 (RD_LATENCY = 1):
  - rvalid = 3'b010 exactly one cycle after issue, rdata = 8'hA7.
  - rvalid[0] and rvalid[2] stay 0.
- req = 3'b111 held continuously, each owner drops req for one cycle after one access:
  - Round-robin build: grant order 0, 1, 2, 0 with a gnt = 0 cycle between owners.
  - SMEM_ARB_FIXED_PRIO_EN build: order 2, 2, ...
- Shuffle swap with lock[1] = 1, req[1] toggled between four accesses while req[2] = 1:
  - gnt stays 3'b010 throughout the swap.
  - gnt[2] is asserted only after lock[1] and req[1] are both 0.
- RD_LATENCY = 3, owner 0 issues a read then releases immediately; requester 2 is granted:
  - rvalid[0] pulses 3 cycles after the issue; rvalid[2] stays 0.
- Assert reset_n = 0 mid-read with a tag in flight:
  - gnt, rvalid and mem_wren go to 0 immediately.
  - No rvalid appears after reset release.
